gate_envelope_ctrl: RTL and testbench
=====================================

Name: gate_envelope_ctrl

Overview:
Attack/hold/release controller that sequences the gain applied by the noise-gate multiplier stage. It consumes the per-sample RMS estimate in Q1.15 and runs a hysteretic open/close state machine. It emits a ramped Q1.15 gain word once per audio sample, so that gating no longer switches abruptly. It sits between the RMS detector and the gain-multiply stage of the audio filtering chain.

Parameters:
OPEN_THRESH_Q15, 1200, RMS level (unsigned Q1.15) at or above which the gate opens.
CLOSE_THRESH_Q15, 800, RMS level below which the gate starts closing; must be <= OPEN_THRESH_Q15.
HOLD_SAMPLES, 3, number of quiet samples held at unity gain before release starts; 0 means no hold.
ATTACK_STEP, 16384, gain increment per sample while attacking; must be > 0.
RELEASE_STEP, 8192, gain decrement per sample while releasing; must be > 0.
FLOOR_GAIN_Q15, 0, closed-gate gain; must be < 32767.
CNT_W, 16, hold counter width; must hold HOLD_SAMPLES.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sample_valid  in  1  one-cycle strobe per audio sample; rms_in is valid on this cycle
rms_in  in  16  unsigned Q1.15 RMS estimate
bypass  in  1  forces gain_q15 output to 32767; the FSM keeps running
gain_q15  out  16  unsigned Q1.15 gain to the multiplier
gain_valid  out  1  one-cycle pulse, registered one cycle after sample_valid
state_out  out  3  current FSM state encoding
gate_open  out  1  high in ATTACK, OPEN and HOLD

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=CLOSED, internal gain=FLOOR_GAIN_Q15, hold count=0, gain_valid=0. gain_q15 shows FLOOR_GAIN_Q15, or 32767 if bypass is high. gate_open=0.
- Reset asserted mid-ramp returns the block to CLOSED/floor on the next edge. A sample_valid coincident with rst is ignored.
- State, gain and counter change only on cycles where sample_valid=1. Otherwise everything holds and gain_valid=0.
- Latency: the registered gain and state for a sample appear on the edge after sample_valid, together with a gain_valid pulse.
- Saturating arithmetic is done in 17 bits:
  - up(g) = min(g+ATTACK_STEP, 32767)
  - dn(g) = max(g-RELEASE_STEP, FLOOR_GAIN_Q15)
  - All comparisons are unsigned.
- Transitions per valid sample. "hi" means rms_in >= OPEN_THRESH_Q15; "lo" means rms_in < CLOSE_THRESH_Q15.
  - CLOSED:
    - hi: gain=up(FLOOR). Go to OPEN if the result is 32767, else ATTACK.
    - otherwise: gain=FLOOR, stay.
  - ATTACK:
    - lo: gain=dn(gain). Go to CLOSED if the result is FLOOR, else RELEASE.
    - otherwise: gain=up(gain). Go to OPEN if the result is 32767.
  - OPEN:
    - lo with HOLD_SAMPLES=0: gain=dn(32767), go to RELEASE (CLOSED if the result is FLOOR).
    - lo with HOLD_SAMPLES>0: cnt=HOLD_SAMPLES-1, gain=32767, go to HOLD.
    - otherwise: stay, gain=32767.
  - HOLD:
    - hi: go to OPEN.
    - otherwise, cnt==0: gain=dn(32767), go to RELEASE (CLOSED if the result is FLOOR).
    - otherwise: cnt--, gain stays 32767.
    - RMS between the thresholds counts as quiet.
  - RELEASE:
    - hi: gain=up(gain). Go to OPEN if the result is 32767, else ATTACK.
    - otherwise: gain=dn(gain). Go to CLOSED if the result is FLOOR.
- Hysteresis: RMS between the thresholds never opens a closed gate and never starts closing an open gate.
- Net effect: exactly HOLD_SAMPLES quiet samples, including the triggering one, are output at unity before release.
- Illegal state encodings recover to CLOSED with gain=FLOOR on the next valid sample.
- Illegal parameter combinations are flagged by an elaboration-time check that forces $fatal in simulation.

Decomposition:
- Shared header/package gate_pkg:
  - state encodings CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4
  - UNITY_Q15=32767
  - Q15 width constant
- One sub-module, gain_ramp_step:
  - combinational saturating up/down step
  - inputs: gain, step, direction, floor
  - outputs: next gain plus at_unity / at_floor flags
- The FSM, hold counter and output registers live in gate_envelope_ctrl.

Test Plan:
All scenarios use default parameters.
1. Reset, then 4 valid samples with rms=500 -> gain_q15=0 and state CLOSED each time. gain_valid pulses exactly 1 cycle after each sample_valid and never otherwise.
2. From CLOSED, rms=1500 x2 -> gains 16384 (ATTACK), then 32767 (OPEN). gate_open=1 from the first.
3. From OPEN, rms=500 x7 -> gains 32767, 32767, 32767, 24575, 16383, 8191, 0. States HOLD, HOLD, HOLD, RELEASE, RELEASE, RELEASE, CLOSED.
4. Hysteresis:
   - From CLOSED, rms=1000 x3 -> stays CLOSED at 0.
   - From OPEN, rms=1000 x3 -> stays OPEN at 32767.
   - rms=1200 exactly opens; rms=800 exactly does not close.
5. Retrigger and abort:
   - OPEN, then rms=500 x2, then 1500 -> back to OPEN. A further 3 quiet samples are again unity.
   - During RELEASE at gain 16383, rms=1500 -> 32767 and OPEN.
6. Bypass and reset:
   - bypass=1 while CLOSED -> gain_q15=32767 and state_out still CLOSED.
   - rst asserted in ATTACK at gain 16384 -> next cycle CLOSED, gain 0, gain_valid 0.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and constants for the noise-gate envelope controller.
// State encodings are visible on state_out, so their values are fixed.
package gate_pkg;

    localparam int Q15_W = 16;

    localparam logic [Q15_W-1:0] UNITY_Q15 = 16'd32767;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_e;

endpackage

// File: rtl/gain_ramp_step.sv
// Saturating one-sample gain step, up toward unity or down toward the floor.
// The arithmetic is done in 17 bits so overflow and borrow are both visible.
module gain_ramp_step
    import gate_pkg::*;
(
    input  logic [Q15_W-1:0] gain_i,
    input  logic [Q15_W-1:0] step_i,
    input  logic             up_i,
    input  logic [Q15_W-1:0] floor_i,
    output logic [Q15_W-1:0] gain_o,
    output logic             at_unity_o,
    output logic             at_floor_o
);

    logic [Q15_W:0] sum;
    logic [Q15_W:0] diff;

    always_comb begin
        sum    = {1'b0, gain_i} + {1'b0, step_i};
        diff   = {1'b0, gain_i} - {1'b0, step_i};
        gain_o = floor_i;
        if (up_i) begin
            if (sum >= {1'b0, UNITY_Q15}) begin
                gain_o = UNITY_Q15;
            end else begin
                gain_o = sum[Q15_W-1:0];
            end
        end else if (!diff[Q15_W] && (diff >= {1'b0, floor_i})) begin
            gain_o = diff[Q15_W-1:0];
        end
        at_unity_o = (gain_o == UNITY_Q15);
        at_floor_o = (gain_o == floor_i);
    end

endmodule

// File: rtl/gate_envelope_ctrl.sv
// Attack/hold/release gate controller: hysteretic FSM that ramps a Q1.15
// gain once per audio sample for the downstream gain multiplier.
module gate_envelope_ctrl
    import gate_pkg::*;
#(
    parameter int OPEN_THRESH_Q15  = 1200,
    parameter int CLOSE_THRESH_Q15 = 800,
    parameter int HOLD_SAMPLES     = 3,
    parameter int ATTACK_STEP      = 16384,
    parameter int RELEASE_STEP     = 8192,
    parameter int FLOOR_GAIN_Q15   = 0,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [Q15_W-1:0] rms_in,
    input  logic             bypass,
    output logic [Q15_W-1:0] gain_q15,
    output logic             gain_valid,
    output logic [2:0]       state_out,
    output logic             gate_open
);

    if ((CLOSE_THRESH_Q15 > OPEN_THRESH_Q15) || (OPEN_THRESH_Q15 > 65535) ||
        (CLOSE_THRESH_Q15 < 0) || (ATTACK_STEP <= 0) ||
        (ATTACK_STEP > 65535) || (RELEASE_STEP <= 0) ||
        (RELEASE_STEP > 65535) || (FLOOR_GAIN_Q15 < 0) ||
        (FLOOR_GAIN_Q15 >= 32767) || (HOLD_SAMPLES < 0) ||
        (CNT_W < 1) || (CNT_W > 30) ||
        (HOLD_SAMPLES >= (1 << CNT_W))) begin : g_bad_param
        $fatal(1, "gate_envelope_ctrl: illegal parameter combination");
    end

    localparam logic [Q15_W-1:0] OPEN_T   = Q15_W'(OPEN_THRESH_Q15);
    localparam logic [Q15_W-1:0] CLOSE_T  = Q15_W'(CLOSE_THRESH_Q15);
    localparam logic [Q15_W-1:0] ATK_STEP = Q15_W'(ATTACK_STEP);
    localparam logic [Q15_W-1:0] REL_STEP = Q15_W'(RELEASE_STEP);
    localparam logic [Q15_W-1:0] FLOOR    = Q15_W'(FLOOR_GAIN_Q15);
    localparam logic [CNT_W-1:0] HOLD_M1  =
        (HOLD_SAMPLES > 0) ? CNT_W'(HOLD_SAMPLES - 1) : '0;

    gate_state_e      state_q, state_d;
    logic [Q15_W-1:0] gain_q, gain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gain_valid_q, gain_valid_d;

    logic             hi, lo;
    logic [Q15_W-1:0] ramp_base, ramp_gain;
    logic             ramp_up, ramp_unity, ramp_floor;

    assign hi = (rms_in >= OPEN_T);
    assign lo = (rms_in < CLOSE_T);

    // One shared stepper: pick its start point and direction from the state.
    always_comb begin
        ramp_base = FLOOR;
        ramp_up   = hi;
        case (state_q)
            ATTACK: begin
                ramp_base = gain_q;
                ramp_up   = !lo;
            end
            RELEASE: ramp_base = gain_q;
            OPEN, HOLD: begin
                ramp_base = UNITY_Q15;
                ramp_up   = 1'b0;
            end
            default: ramp_base = FLOOR;
        endcase
    end

    gain_ramp_step u_ramp (
        .gain_i     (ramp_base),
        .step_i     (ramp_up ? ATK_STEP : REL_STEP),
        .up_i       (ramp_up),
        .floor_i    (FLOOR),
        .gain_o     (ramp_gain),
        .at_unity_o (ramp_unity),
        .at_floor_o (ramp_floor)
    );

    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        cnt_d        = cnt_q;
        gain_valid_d = sample_valid;
        if (sample_valid) begin
            case (state_q)
                CLOSED: begin
                    gain_d = FLOOR;
                    if (hi) begin
                        gain_d  = ramp_gain;
                        state_d = ramp_unity ? OPEN : ATTACK;
                    end
                end
                ATTACK: begin
                    gain_d = ramp_gain;
                    if (lo) begin
                        state_d = ramp_floor ? CLOSED : RELEASE;
                    end else if (ramp_unity) begin
                        state_d = OPEN;
                    end
                end
                OPEN: begin
                    gain_d = UNITY_Q15;
                    if (lo && (HOLD_SAMPLES == 0)) begin
                        gain_d  = ramp_gain;
                        state_d = ramp_floor ? CLOSED : RELEASE;
                    end else if (lo) begin
                        cnt_d   = HOLD_M1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    gain_d = UNITY_Q15;
                    if (hi) begin
                        state_d = OPEN;
                    end else if (cnt_q == '0) begin
                        gain_d  = ramp_gain;
                        state_d = ramp_floor ? CLOSED : RELEASE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RELEASE: begin
                    gain_d = ramp_gain;
                    if (hi) begin
                        state_d = ramp_unity ? OPEN : ATTACK;
                    end else if (ramp_floor) begin
                        state_d = CLOSED;
                    end
                end
                default: begin
                    state_d = CLOSED;
                    gain_d  = FLOOR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLOSED;
            gain_q       <= FLOOR;
            cnt_q        <= '0;
            gain_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            cnt_q        <= cnt_d;
            gain_valid_q <= gain_valid_d;
        end
    end

    assign gain_q15   = bypass ? UNITY_Q15 : gain_q;
    assign gain_valid = gain_valid_q;
    assign state_out  = state_q;
    assign gate_open  = (state_q == ATTACK) || (state_q == OPEN) ||
                        (state_q == HOLD);

endmodule

// File: tb/tb_gate_envelope_ctrl.sv
// Scoreboard bench for gate_envelope_ctrl: a behavioural gate model queues
// expected outputs per sample, and a monitor checks each gain_valid pulse.
module tb_gate_envelope_ctrl;

    localparam int OPEN_T  = 1200;
    localparam int CLOSE_T = 800;
    localparam int HOLD_N  = 3;
    localparam int ATK     = 16384;
    localparam int REL     = 8192;
    localparam int FLOOR_G = 0;
    localparam int UNITY   = 32767;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [15:0] rms_in;
    logic        bypass;
    logic [15:0] gain_q15;
    logic        gain_valid;
    logic [2:0]  state_out;
    logic        gate_open;

    gate_envelope_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .rms_in       (rms_in),
        .bypass       (bypass),
        .gain_q15     (gain_q15),
        .gain_valid   (gain_valid),
        .state_out    (state_out),
        .gate_open    (gate_open)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gain;
        int state;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Model: mode 0..4 = closed/attack/open/hold/release, held = unity quiet
    // samples already emitted since the gate went quiet.
    int m_mode;
    int m_gain;
    int m_held;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int up_g(input int g);
        return (g + ATK > UNITY) ? UNITY : g + ATK;
    endfunction

    function automatic int dn_g(input int g);
        return (g - REL < FLOOR_G) ? FLOOR_G : g - REL;
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_gain = FLOOR_G;
        m_held = 0;
    endfunction

    function automatic void start_release(input int from_gain);
        m_gain = dn_g(from_gain);
        m_mode = (m_gain == FLOOR_G) ? 0 : 4;
    endfunction

    function automatic void start_attack(input int from_gain);
        m_gain = up_g(from_gain);
        m_mode = (m_gain == UNITY) ? 2 : 1;
    endfunction

    function automatic void model_step(input int rms);
        bit hi;
        bit lo;
        hi = (rms >= OPEN_T);
        lo = (rms < CLOSE_T);
        if (m_mode == 0) begin
            if (hi) start_attack(FLOOR_G);
            else m_gain = FLOOR_G;
        end else if (m_mode == 1) begin
            if (lo) start_release(m_gain);
            else start_attack(m_gain);
        end else if (m_mode == 2) begin
            m_gain = UNITY;
            if (lo) begin
                if (HOLD_N == 0) begin
                    start_release(UNITY);
                end else begin
                    m_held = 1;
                    m_mode = 3;
                end
            end
        end else if (m_mode == 3) begin
            if (hi) begin
                m_mode = 2;
            end else if (m_held >= HOLD_N) begin
                start_release(UNITY);
            end else begin
                m_held++;
            end
        end else begin
            if (hi) start_attack(m_gain);
            else start_release(m_gain);
        end
    endfunction

    task automatic send(input int rms, input bit byp = 1'b0);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        rms_in       = 16'(rms);
        bypass       = byp;
        model_step(rms);
        sb.push_back('{gain: m_gain, state: m_mode});
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_n(input int rms, input int n);
        for (int i = 0; i < n; i++) send(rms);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    endtask

    task automatic do_reset(input bit with_valid);
        drain();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        sample_valid = with_valid;
        rms_in       = 16'd1500;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        chk("reset_state", int'(state_out), 0);
        chk("reset_gain", int'(gain_q15), bypass ? UNITY : FLOOR_G);
        chk("reset_gate_open", int'(gate_open), 0);
        chk("reset_gain_valid", int'(gain_valid), 0);
    endtask

    initial begin : monitor
        int   waits;
        exp_t e;
        waits = 0;
        forever begin
            @(negedge clk);
            if (gain_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_gain_valid", 1, 0);
                end else begin
                    e     = sb.pop_front();
                    waits = 0;
                    chk("gain", int'(gain_q15), bypass ? UNITY : e.gain);
                    chk("state", int'(state_out), e.state);
                    chk("gate_open", int'(gate_open),
                        (e.state >= 1 && e.state <= 3) ? 1 : 0);
                end
            end else if (sb.size() > 0) begin
                waits++;
                if (waits > 2) begin
                    chk("gain_valid_timeout", 0, 1);
                    sb.delete();
                    waits = 0;
                end
            end
        end
    end

    initial begin : stim
        int r;
        int rms;
        rst          = 1'b1;
        sample_valid = 1'b0;
        bypass       = 1'b0;
        rms_in       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("por_state", int'(state_out), 0);
        chk("por_gain", int'(gain_q15), 0);
        chk("por_gate_open", int'(gate_open), 0);
        chk("por_gain_valid", int'(gain_valid), 0);

        send_n(500, 4);
        send_n(1500, 2);
        send_n(500, 7);

        send_n(1000, 3);
        send(1200);
        send(1500);
        send_n(1000, 3);
        send(800);

        send_n(500, 2);
        send(1500);
        send_n(500, 3);
        send_n(500, 2);
        send(1500);

        send_n(500, 7);
        send(500, 1'b1);
        send(500);
        send(1500);
        do_reset(1'b1);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                case ($urandom_range(0, 5))
                    0: rms = 799 + $urandom_range(0, 2);
                    1: rms = 1199 + $urandom_range(0, 2);
                    2: rms = $urandom_range(0, 65535);
                    3: rms = $urandom_range(0, 799);
                    4: rms = $urandom_range(1200, 3000);
                    default: rms = $urandom_range(800, 1199);
                endcase
                send(rms, ($urandom_range(0, 9) == 0));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                end
            end
        end

        drain();
        repeat (2) @(posedge clk);
        chk("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
